// File: rtl/keyboard_pkg.sv
// Shared definitions for the PS/2 keyboard decoder: parser states, scan-code
// constants and the bytes dropped outside of a prefix sequence.
package keyboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_SPACE = 8'h29;

  localparam int N_DISCARD = 5;
  localparam logic [7:0] DISCARD_BYTES [N_DISCARD] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00};

  function automatic logic is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_DISCARD; i++) begin
      if (b == DISCARD_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/scancode_parser.sv
// Folds E0/F0 prefix bytes into completed {extended, byte} codes with a
// make/break flag; abandons a pending prefix after a stall of TIMEOUT_CYCLES.
//
// state      | meaning
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen
// ST_BRK     | F0 seen
// ST_EXT_BRK | E0 then F0 seen
module scancode_parser
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       dinValid,
  output logic [8:0] code,
  output logic       brk,
  output logic       valid
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

  parse_state_t state, state_nxt;
  logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  // A consumed byte always wins over an expiring timer on the same cycle.
  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    code        = {1'b0, din};
    brk         = 1'b0;
    valid       = 1'b0;
    if (dinValid) begin
      tmo_cnt_nxt = TMO_LOAD;
      case (state)
        ST_IDLE: begin
          if (din == PREFIX_EXT)      state_nxt = ST_EXT;
          else if (din == PREFIX_BRK) state_nxt = ST_BRK;
          else if (!is_discard(din))  valid = 1'b1;
        end
        ST_EXT: begin
          if (din == PREFIX_BRK)      state_nxt = ST_EXT_BRK;
          else if (din != PREFIX_EXT) begin
            code      = {1'b1, din};
            valid     = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk       = 1'b1;
          valid     = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: begin
          code      = {1'b1, din};
          brk       = 1'b1;
          valid     = 1'b1;
          state_nxt = ST_IDLE;
        end
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo_cnt == '0) state_nxt = ST_IDLE;
      else               tmo_cnt_nxt = tmo_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/keyboard_decoder.sv
// Tracks held keys from parsed scan codes: last-pressed-wins arrow direction,
// one-shot space press, and a strobe for every completed make/break.
module keyboard_decoder
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       dinValid,
  output logic       rightArrow,
  output logic       leftArrow,
  output logic       spaceBar,
  output logic [8:0] keyCode,
  output logic       keyPulse,
  output logic       keyBreak
);

  logic [8:0] ev_code;
  logic       ev_brk, ev_valid;

  scancode_parser #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_parser (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .dinValid (dinValid),
    .code     (ev_code),
    .brk      (ev_brk),
    .valid    (ev_valid)
  );

  logic right_held, left_held, space_held;
  logic right_held_nxt, left_held_nxt, space_held_nxt;
  logic right_nxt, left_nxt, space_nxt, pulse_nxt, break_nxt;
  logic [8:0] code_nxt;
  logic is_right, is_left, is_space;

  assign is_right = (ev_code == {1'b1, CODE_RIGHT});
  assign is_left  = (ev_code == {1'b1, CODE_LEFT});
  assign is_space = (ev_code == {1'b0, CODE_SPACE});

  always_comb begin
    right_held_nxt = right_held;
    left_held_nxt  = left_held;
    space_held_nxt = space_held;
    right_nxt      = rightArrow;
    left_nxt       = leftArrow;
    code_nxt       = keyCode;
    break_nxt      = keyBreak;
    space_nxt      = 1'b0;
    pulse_nxt      = 1'b0;
    if (ev_valid) begin
      code_nxt  = ev_code;
      break_nxt = ev_brk;
      pulse_nxt = 1'b1;
      if (is_right) begin
        right_held_nxt = !ev_brk;
        if (!ev_brk) begin
          right_nxt = 1'b1;
          left_nxt  = 1'b0;
        end else if (rightArrow) begin
          right_nxt = 1'b0;
          left_nxt  = left_held;
        end
      end
      if (is_left) begin
        left_held_nxt = !ev_brk;
        if (!ev_brk) begin
          left_nxt  = 1'b1;
          right_nxt = 1'b0;
        end else if (leftArrow) begin
          left_nxt  = 1'b0;
          right_nxt = right_held;
        end
      end
      // Typematic repeats arrive as further makes while already held.
      if (is_space) begin
        space_held_nxt = !ev_brk;
        space_nxt      = !ev_brk && !space_held;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      right_held <= 1'b0;
      left_held  <= 1'b0;
      space_held <= 1'b0;
      rightArrow <= 1'b0;
      leftArrow  <= 1'b0;
      spaceBar   <= 1'b0;
      keyCode    <= 9'h000;
      keyPulse   <= 1'b0;
      keyBreak   <= 1'b0;
    end else begin
      right_held <= right_held_nxt;
      left_held  <= left_held_nxt;
      space_held <= space_held_nxt;
      rightArrow <= right_nxt;
      leftArrow  <= left_nxt;
      spaceBar   <= space_nxt;
      keyCode    <= code_nxt;
      keyPulse   <= pulse_nxt;
      keyBreak   <= break_nxt;
    end
  end

endmodule
